fd_instr_queue: RTL and testbench

//  Parametrised fetch->decode boundary: replaces the single-entry F/D register with a DEPTH-entry
//  in-order queue of {instruction, PC, predicted-take bit}. Decouples fetch from decode stalls.

---
 rtl/fd_pkg.sv | 20 ++
 rtl/queue_ptr_ctrl.sv | 54 +++++
 rtl/fd_instr_queue.sv | 84 ++++++++
 tb/tb_fd_instr_queue.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// Shared types for the fetch->decode boundary queue.
package fd_pkg;

  localparam int unsigned FD_XLEN = 32;
  localparam int unsigned FD_ILEN = 32;

  typedef struct packed {
    logic [FD_ILEN-1:0] instr;
    logic [FD_XLEN-1:0] pc;
    logic               take_jb;
  } fd_entry_t;

  // Bubble presented to decode when nothing is queued; matches a flushed F/D register.
  localparam fd_entry_t FD_BUBBLE = '0;

  function automatic bit isPow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/queue_ptr_ctrl.sv
// Pointer/occupancy control for a power-of-two in-order queue with flush.
module queue_ptr_ctrl #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTRW  = $clog2(DEPTH),
  localparam int unsigned CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            iClk,
  input  logic            iRstN,
  input  logic            iValid,
  input  logic            iStall,
  input  logic            iFlush,
  output logic            oReady,
  output logic            oValid,
  output logic            oPush,
  output logic            oPop,
  output logic [PTRW-1:0] oWrPtr,
  output logic [PTRW-1:0] oRdPtr,
  output logic [CNTW-1:0] oCount
);

  logic [PTRW-1:0] wrPtr;
  logic [PTRW-1:0] rdPtr;
  logic [CNTW-1:0] count;

  // Handshake qualification from registered occupancy only; flush suppresses both sides.
  always_comb begin
    oReady = (count != CNTW'(DEPTH));
    oValid = (count != '0);
    oPush  = iValid & oReady & ~iFlush;
    oPop   = oValid & ~iStall & ~iFlush;
  end

  // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (iFlush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (oPush) wrPtr <= wrPtr + 1'b1;
      if (oPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CNTW'(oPush) - CNTW'(oPop);
    end
  end

  assign oWrPtr = wrPtr;
  assign oRdPtr = rdPtr;
  assign oCount = count;

endmodule

// File: rtl/fd_instr_queue.sv
// Fetch->decode queue: DEPTH entries of {instruction, PC, predicted-take}, valid/ready in, stall/flush out.
module fd_instr_queue
  import fd_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       iClk,
  input  logic                       iRstN,
  input  logic                       iValidF,
  input  logic [ILEN-1:0]            iInstructionF,
  input  logic [XLEN-1:0]            iPCF,
  input  logic                       iTakeJBF,
  output logic                       oReadyF,
  input  logic                       iStallD,
  input  logic                       iFlushD,
  output logic                       oValidD,
  output logic [ILEN-1:0]            oInstructionD,
  output logic [XLEN-1:0]            oPCD,
  output logic                       oTakeJBD,
  output logic [$clog2(DEPTH+1)-1:0] oCount
);

  localparam int unsigned PTRW = $clog2(DEPTH);

  if (!isPow2(DEPTH) || DEPTH < 2) begin : gBadDepth
    $error("fd_instr_queue: DEPTH must be a power of two >= 2");
  end
  if (XLEN != FD_XLEN || ILEN != FD_ILEN) begin : gBadWidth
    $error("fd_instr_queue: XLEN/ILEN must match fd_entry_t field widths");
  end

  logic            push;
  logic            pop;
  logic [PTRW-1:0] wrPtr;
  logic [PTRW-1:0] rdPtr;
  fd_entry_t       mem [DEPTH];
  fd_entry_t       inEntry;
  fd_entry_t       headEntry;

  queue_ptr_ctrl #(.DEPTH(DEPTH)) uPtrCtrl (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iValid (iValidF),
    .iStall (iStallD),
    .iFlush (iFlushD),
    .oReady (oReadyF),
    .oValid (oValidD),
    .oPush  (push),
    .oPop   (pop),
    .oWrPtr (wrPtr),
    .oRdPtr (rdPtr),
    .oCount (oCount)
  );

  // Pack the fetch-side fields into one entry.
  always_comb begin
    inEntry         = FD_BUBBLE;
    inEntry.instr   = iInstructionF;
    inEntry.pc      = iPCF;
    inEntry.take_jb = iTakeJBF;
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge iClk) begin
    if (push) mem[wrPtr] <= inEntry;
  end

  // Head presented to decode, forced to a bubble when empty.
  always_comb begin
    headEntry = FD_BUBBLE;
    if (oValidD) headEntry = mem[rdPtr];
  end

  assign oInstructionD = headEntry.instr;
  assign oPCD          = headEntry.pc;
  assign oTakeJBD      = headEntry.take_jb;

  // pop is only consumed by the pointer control; kept visible here for debug.
  logic unusedPop;
  assign unusedPop = pop;

endmodule

// File: tb/tb_fd_instr_queue.sv
// Directed self-checking bench for fd_instr_queue (DEPTH=4).
module tb_fd_instr_queue;

  logic        iClk = 1'b0;
  logic        iRstN;
  logic        iValidF;
  logic [31:0] iInstructionF;
  logic [31:0] iPCF;
  logic        iTakeJBF;
  logic        oReadyF;
  logic        iStallD;
  logic        iFlushD;
  logic        oValidD;
  logic [31:0] oInstructionD;
  logic [31:0] oPCD;
  logic        oTakeJBD;
  logic [2:0]  oCount;

  int unsigned nVec = 0;
  int unsigned nMis = 0;

  fd_instr_queue #(.XLEN(32), .ILEN(32), .DEPTH(4)) uDut (
    .iClk          (iClk),
    .iRstN         (iRstN),
    .iValidF       (iValidF),
    .iInstructionF (iInstructionF),
    .iPCF          (iPCF),
    .iTakeJBF      (iTakeJBF),
    .oReadyF       (oReadyF),
    .iStallD       (iStallD),
    .iFlushD       (iFlushD),
    .oValidD       (oValidD),
    .oInstructionD (oInstructionD),
    .oPCD          (oPCD),
    .oTakeJBD      (oTakeJBD),
    .oCount        (oCount)
  );

  always #5 iClk = ~iClk;

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic tk);
    iValidF       = v;
    iPCF          = pc;
    iInstructionF = instrOf(pc);
    iTakeJBF      = tk;
  endtask

  task automatic chkEmpty(input string tag);
    chk({tag, ".valid"}, 64'(oValidD), 64'd0);
    chk({tag, ".count"}, 64'(oCount), 64'd0);
    chk({tag, ".ready"}, 64'(oReadyF), 64'd1);
    chk({tag, ".pc"}, 64'(oPCD), 64'd0);
    chk({tag, ".instr"}, 64'(oInstructionD), 64'd0);
    chk({tag, ".take"}, 64'(oTakeJBD), 64'd0);
  endtask

  initial begin
    iRstN = 1'b0;
    iStallD = 1'b0;
    iFlushD = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #12;
    chkEmpty("rst0");
    iRstN = 1'b1;
    step();

    // Fill under stall, then drain in order.
    iStallD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0);
      step();
    end
    chk("fill.count", 64'(oCount), 64'd4);
    chk("fill.ready", 64'(oReadyF), 64'd0);
    drive(1'b1, 32'h10, 1'b1);
    step();
    chk("fill.drop.count", 64'(oCount), 64'd4);
    drive(1'b0, 32'h0, 1'b0);
    iStallD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain.pc", 64'(oPCD), 64'(4 * i));
      chk("drain.instr", 64'(oInstructionD), 64'(instrOf(32'(4 * i))));
      step();
    end
    chkEmpty("drain.end");

    // Streaming: one push and one pop per cycle, pointers wrap twice.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 1'(i % 2));
      step();
      chk("stream.count", 64'(oCount), 64'd1);
      chk("stream.pc", 64'(oPCD), 64'(32'h100 + 32'(4 * i)));
      chk("stream.take", 64'(oTakeJBD), 64'(i % 2));
    end
    drive(1'b0, 32'h0, 1'b0);
    step();
    chkEmpty("stream.end");

    // Full with simultaneous fetch and pop: only the pop happens.
    iStallD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 1'b0);
      step();
    end
    chk("full.count", 64'(oCount), 64'd4);
    iStallD = 1'b0;
    drive(1'b1, 32'h210, 1'b0);
    step();
    chk("fullpop.count", 64'(oCount), 64'd3);
    chk("fullpop.ready", 64'(oReadyF), 64'd1);
    chk("fullpop.pc", 64'(oPCD), 64'h204);
    drive(1'b1, 32'h214, 1'b0);
    step();
    chk("pushpop.count", 64'(oCount), 64'd3);
    chk("pushpop.pc", 64'(oPCD), 64'h208);

    // Flush with an incoming fetch: everything dropped.
    iFlushD = 1'b1;
    drive(1'b1, 32'h40, 1'b1);
    step();
    chkEmpty("flush");
    iFlushD = 1'b0;
    iStallD = 1'b1;
    drive(1'b1, 32'h80, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0);
    chk("postflush.count", 64'(oCount), 64'd1);
    chk("postflush.pc", 64'(oPCD), 64'h80);
    chk("postflush.take", 64'(oTakeJBD), 64'd1);
    iStallD = 1'b0;
    step();
    chkEmpty("postflush.drain");

    // Stall hold: head stays put while the queue fills behind it.
    iStallD = 1'b1;
    iValidF = 1'b1;
    iPCF = 32'h300;
    iInstructionF = 32'h0050_0093;
    iTakeJBF = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h304 + 32'(4 * k), 1'b0);
      step();
      chk("hold.instr", 64'(oInstructionD), 64'h0050_0093);
      chk("hold.take", 64'(oTakeJBD), 64'd1);
      chk("hold.count", 64'(oCount), 64'((k + 2 > 4) ? 4 : k + 2));
    end
    drive(1'b0, 32'h0, 1'b0);
    iStallD = 1'b0;
    step();
    chk("hold.adv.pc", 64'(oPCD), 64'h304);
    chk("hold.adv.instr", 64'(oInstructionD), 64'(instrOf(32'h304)));
    chk("hold.adv.take", 64'(oTakeJBD), 64'd0);
    chk("hold.adv.count", 64'(oCount), 64'd3);

    // Asynchronous reset with three entries held.
    iStallD = 1'b1;
    #2;
    iRstN = 1'b0;
    #1;
    chkEmpty("asyncrst");
    #3;
    iRstN = 1'b1;
    iStallD = 1'b0;
    step();
    chkEmpty("asyncrst.after");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
